// File: rtl/y86_pkg.sv
// Y86-64 encoding constants and source/destination register selects,
// shared by the decode reader and the writeBack stage.
package y86_pkg;

   localparam int unsigned ID_W   = 4;
   localparam int unsigned CODE_W = 4;

   localparam logic [CODE_W-1:0] I_HALT   = 4'h0;
   localparam logic [CODE_W-1:0] I_NOP    = 4'h1;
   localparam logic [CODE_W-1:0] I_RRMOVQ = 4'h2;
   localparam logic [CODE_W-1:0] I_IRMOVQ = 4'h3;
   localparam logic [CODE_W-1:0] I_RMMOVQ = 4'h4;
   localparam logic [CODE_W-1:0] I_MRMOVQ = 4'h5;
   localparam logic [CODE_W-1:0] I_OPQ    = 4'h6;
   localparam logic [CODE_W-1:0] I_JXX    = 4'h7;
   localparam logic [CODE_W-1:0] I_CALL   = 4'h8;
   localparam logic [CODE_W-1:0] I_RET    = 4'h9;
   localparam logic [CODE_W-1:0] I_PUSHQ  = 4'hA;
   localparam logic [CODE_W-1:0] I_POPQ   = 4'hB;

   localparam logic [ID_W-1:0] RNONE = 4'hF;
   localparam logic [ID_W-1:0] RRSP  = 4'h4;

   function automatic logic [ID_W-1:0] src_a_sel(input logic [CODE_W-1:0] icode,
                                                 input logic [ID_W-1:0]   ra);
      logic [ID_W-1:0] id;
      id = RNONE;
      case (icode)
         I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: id = ra;
         I_RET, I_POPQ:                      id = RRSP;
         default:                            id = RNONE;
      endcase
      return id;
   endfunction

   function automatic logic [ID_W-1:0] src_b_sel(input logic [CODE_W-1:0] icode,
                                                 input logic [ID_W-1:0]   rb);
      logic [ID_W-1:0] id;
      id = RNONE;
      case (icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ:          id = rb;
         I_CALL, I_RET, I_PUSHQ, I_POPQ:     id = RRSP;
         default:                            id = RNONE;
      endcase
      return id;
   endfunction

   // cmovXX that did not take its condition writes nothing.
   function automatic logic [ID_W-1:0] dst_e_sel(input logic [CODE_W-1:0] icode,
                                                 input logic [ID_W-1:0]   rb,
                                                 input logic              cnd);
      logic [ID_W-1:0] id;
      id = RNONE;
      case (icode)
         I_IRMOVQ, I_OPQ:                    id = rb;
         I_RRMOVQ:                           id = cnd ? rb : RNONE;
         I_CALL, I_RET, I_PUSHQ, I_POPQ:     id = RRSP;
         default:                            id = RNONE;
      endcase
      return id;
   endfunction

   function automatic logic [ID_W-1:0] dst_m_sel(input logic [CODE_W-1:0] icode,
                                                 input logic [ID_W-1:0]   ra);
      logic [ID_W-1:0] id;
      id = RNONE;
      case (icode)
         I_MRMOVQ, I_POPQ:                   id = ra;
         default:                            id = RNONE;
      endcase
      return id;
   endfunction

endpackage

// File: rtl/y86_regfile.sv
// 15-entry architectural register file: two write ports (M beats E on the
// same id) and two combinational read ports that see same-edge writes.
module y86_regfile
   import y86_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned NREG  = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              we_e,
   input  logic [ID_W-1:0]   dst_e,
   input  logic [WIDTH-1:0]  data_e,
   input  logic              we_m,
   input  logic [ID_W-1:0]   dst_m,
   input  logic [WIDTH-1:0]  data_m,
   input  logic [ID_W-1:0]   src_a,
   input  logic [ID_W-1:0]   src_b,
   output logic [WIDTH-1:0]  rd_a_c,
   output logic [WIDTH-1:0]  rd_b_c
);

   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] regs_d [NREG];

   logic wr_e_c;
   logic wr_m_c;

   assign wr_e_c = we_e && (dst_e != RNONE);
   assign wr_m_c = we_m && (dst_m != RNONE);

   always_comb begin
      regs_d = regs_q;
      if (wr_e_c) regs_d[dst_e] = data_e;
      if (wr_m_c) regs_d[dst_m] = data_m;
   end

   always_ff @(posedge clock) begin
      if (reset) regs_q <= '{default: '0};
      else       regs_q <= regs_d;
   end

   // Bypass order: M write, then E write, then the stored value.
   always_comb begin
      rd_a_c = '0;
      if (src_a != RNONE) begin
         if (wr_m_c && (dst_m == src_a))      rd_a_c = data_m;
         else if (wr_e_c && (dst_e == src_a)) rd_a_c = data_e;
         else                                 rd_a_c = regs_q[src_a];
      end
   end

   always_comb begin
      rd_b_c = '0;
      if (src_b != RNONE) begin
         if (wr_m_c && (dst_m == src_b))      rd_b_c = data_m;
         else if (wr_e_c && (dst_e == src_b)) rd_b_c = data_e;
         else                                 rd_b_c = regs_q[src_b];
      end
   end

endmodule

// File: rtl/decode_reg_read.sv
// Decode-stage register read: selects srcA/srcB, applies write-back from the
// retiring instruction and registers the operands with one cycle latency.
module decode_reg_read
   import y86_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned NREG  = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [3:0]        in_code,
   input  logic [3:0]        ra,
   input  logic [3:0]        rb,
   input  logic              wb_valid,
   input  logic [3:0]        wb_code,
   input  logic [3:0]        wb_ra,
   input  logic [3:0]        wb_rb,
   input  logic              wb_cnd,
   input  logic [WIDTH-1:0]  val_e,
   input  logic [WIDTH-1:0]  val_m,
   output logic              out_valid,
   output logic [WIDTH-1:0]  val_a,
   output logic [WIDTH-1:0]  val_b,
   output logic [3:0]        src_a,
   output logic [3:0]        src_b
);

   logic [ID_W-1:0]  src_a_c, src_b_c;
   logic [ID_W-1:0]  dst_e_c, dst_m_c;
   logic [WIDTH-1:0] rd_a_c, rd_b_c;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] val_a_q, val_a_d;
   logic [WIDTH-1:0] val_b_q, val_b_d;
   logic [ID_W-1:0]  src_a_q, src_a_d;
   logic [ID_W-1:0]  src_b_q, src_b_d;

   always_comb begin
      src_a_c = src_a_sel(in_code, ra);
      src_b_c = src_b_sel(in_code, rb);
      dst_e_c = dst_e_sel(wb_code, wb_rb, wb_cnd);
      dst_m_c = dst_m_sel(wb_code, wb_ra);
   end

   y86_regfile #(
      .WIDTH (WIDTH),
      .NREG  (NREG)
   ) u_regfile (
      .clock  (clock),
      .reset  (reset),
      .we_e   (wb_valid),
      .dst_e  (dst_e_c),
      .data_e (val_e),
      .we_m   (wb_valid),
      .dst_m  (dst_m_c),
      .data_m (val_m),
      .src_a  (src_a_c),
      .src_b  (src_b_c),
      .rd_a_c (rd_a_c),
      .rd_b_c (rd_b_c)
   );

   // Operands and ids hold while no decode request is present.
   always_comb begin
      out_valid_d = in_valid;
      val_a_d     = val_a_q;
      val_b_d     = val_b_q;
      src_a_d     = src_a_q;
      src_b_d     = src_b_q;
      if (in_valid) begin
         val_a_d = rd_a_c;
         val_b_d = rd_b_c;
         src_a_d = src_a_c;
         src_b_d = src_b_c;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         val_a_q     <= '0;
         val_b_q     <= '0;
         src_a_q     <= RNONE;
         src_b_q     <= RNONE;
      end else begin
         out_valid_q <= out_valid_d;
         val_a_q     <= val_a_d;
         val_b_q     <= val_b_d;
         src_a_q     <= src_a_d;
         src_b_q     <= src_b_d;
      end
   end

   assign out_valid = out_valid_q;
   assign val_a     = val_a_q;
   assign val_b     = val_b_q;
   assign src_a     = src_a_q;
   assign src_b     = src_b_q;

endmodule

// File: tb/tb_decode_reg_read.sv
// Directed bench for decode_reg_read: write-back, read latency, bypass,
// cmov suppression, popq M-priority and mid-stream reset.
module tb_decode_reg_read;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [3:0]  in_code, ra, rb;
   logic        wb_valid;
   logic [3:0]  wb_code, wb_ra, wb_rb;
   logic        wb_cnd;
   logic [63:0] val_e, val_m;
   logic        out_valid;
   logic [63:0] val_a, val_b;
   logic [3:0]  src_a, src_b;

   int n_checks = 0;
   int n_fail   = 0;

   decode_reg_read dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_code   (in_code),
      .ra        (ra),
      .rb        (rb),
      .wb_valid  (wb_valid),
      .wb_code   (wb_code),
      .wb_ra     (wb_ra),
      .wb_rb     (wb_rb),
      .wb_cnd    (wb_cnd),
      .val_e     (val_e),
      .val_m     (val_m),
      .out_valid (out_valid),
      .val_a     (val_a),
      .val_b     (val_b),
      .src_a     (src_a),
      .src_b     (src_b)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0; in_code = 4'h1; ra = 4'hF; rb = 4'hF;
      wb_valid = 1'b0; wb_code = 4'h1; wb_ra = 4'hF; wb_rb = 4'hF;
      wb_cnd = 1'b0; val_e = '0; val_m = '0;
   endtask

   task automatic dec(input logic [3:0] c, input logic [3:0] a, input logic [3:0] b);
      in_valid = 1'b1; in_code = c; ra = a; rb = b;
   endtask

   task automatic wb(input logic [3:0] c, input logic [3:0] a, input logic [3:0] b,
                     input logic cnd, input logic [63:0] e, input logic [63:0] m);
      wb_valid = 1'b1; wb_code = c; wb_ra = a; wb_rb = b; wb_cnd = cnd;
      val_e = e; val_m = m;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      tick(); tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      n_checks++; if (src_a !== 4'hF) begin n_fail++; $display("FAIL reset_src_a got %h want f", src_a); end
      n_checks++; if (src_b !== 4'hF) begin n_fail++; $display("FAIL reset_src_b got %h want f", src_b); end
      n_checks++; if (val_a !== 64'd0 || val_b !== 64'd0) begin n_fail++; $display("FAIL reset_vals got %0d/%0d want 0/0", val_a, val_b); end
      reset = 1'b0;
      dec(4'h6, 4'h0, 4'h2);
      tick();
      idle();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_read_valid got %0b want 1", out_valid); end
      n_checks++; if (src_a !== 4'h0 || src_b !== 4'h2) begin n_fail++; $display("FAIL first_read_src got %h/%h want 0/2", src_a, src_b); end
      n_checks++; if (val_a !== 64'd0 || val_b !== 64'd0) begin n_fail++; $display("FAIL first_read_vals got %0d/%0d want 0/0", val_a, val_b); end
   endtask

   task automatic test_write_read();
      wb(4'h3, 4'hF, 4'h2, 1'b0, 64'd21, 64'd0);
      tick();
      idle();
      dec(4'h6, 4'h2, 4'h2);
      tick();
      idle();
      n_checks++; if (val_a !== 64'd21 || val_b !== 64'd21) begin n_fail++; $display("FAIL irmov_read got %0d/%0d want 21/21", val_a, val_b); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %0b want 0", out_valid); end
      n_checks++; if (val_a !== 64'd21 || src_a !== 4'h2) begin n_fail++; $display("FAIL idle_hold got %0d/%h want 21/2", val_a, src_a); end
   endtask

   task automatic test_cmov();
      wb(4'h2, 4'h0, 4'h3, 1'b0, 64'd77, 64'd0);
      tick();
      idle();
      dec(4'h6, 4'h3, 4'h3);
      tick();
      idle();
      n_checks++; if (val_a !== 64'd0) begin n_fail++; $display("FAIL cmov_not_taken got %0d want 0", val_a); end
      wb(4'h2, 4'h0, 4'h3, 1'b1, 64'd77, 64'd0);
      tick();
      idle();
      dec(4'h6, 4'h3, 4'h3);
      tick();
      idle();
      n_checks++; if (val_a !== 64'd77 || val_b !== 64'd77) begin n_fail++; $display("FAIL cmov_taken got %0d/%0d want 77/77", val_a, val_b); end
   endtask

   task automatic test_bypass_m();
      wb(4'h5, 4'h5, 4'hF, 1'b0, 64'd999, 64'd262);
      dec(4'h4, 4'h5, 4'h4);
      tick();
      idle();
      n_checks++; if (val_a !== 64'd262) begin n_fail++; $display("FAIL bypass_m_a got %0d want 262", val_a); end
      n_checks++; if (val_b !== 64'd0 || src_b !== 4'h4) begin n_fail++; $display("FAIL bypass_m_b got %0d/%h want 0/4", val_b, src_b); end
   endtask

   task automatic test_popq();
      wb(4'hB, 4'h4, 4'hF, 1'b0, 64'd81, 64'd66);
      tick();
      idle();
      dec(4'h9, 4'hF, 4'hF);
      tick();
      idle();
      n_checks++; if (src_a !== 4'h4 || src_b !== 4'h4) begin n_fail++; $display("FAIL ret_src got %h/%h want 4/4", src_a, src_b); end
      n_checks++; if (val_a !== 64'd66 || val_b !== 64'd66) begin n_fail++; $display("FAIL popq_m_wins got %0d/%0d want 66/66", val_a, val_b); end
      // same-edge popq against a pushq read of rsp
      wb(4'hB, 4'h4, 4'hF, 1'b0, 64'd90, 64'd55);
      dec(4'hA, 4'h2, 4'hF);
      tick();
      idle();
      n_checks++; if (val_a !== 64'd21 || val_b !== 64'd55) begin n_fail++; $display("FAIL popq_bypass got %0d/%0d want 21/55", val_a, val_b); end
   endtask

   task automatic test_no_src();
      dec(4'h1, 4'h2, 4'h2);
      tick();
      idle();
      n_checks++; if (src_a !== 4'hF || src_b !== 4'hF || val_a !== 64'd0 || val_b !== 64'd0)
         begin n_fail++; $display("FAIL nop_read got %h/%h %0d/%0d want f/f 0/0", src_a, src_b, val_a, val_b); end
      dec(4'h3, 4'h2, 4'h3);
      tick();
      idle();
      n_checks++; if (src_b !== 4'hF || val_b !== 64'd0 || val_a !== 64'd0)
         begin n_fail++; $display("FAIL irmov_read_none got %h %0d/%0d want f 0/0", src_b, val_a, val_b); end
   endtask

   task automatic test_back_to_back();
      wb(4'h3, 4'hF, 4'h7, 1'b0, 64'd5, 64'd0);
      dec(4'h6, 4'h7, 4'h3);
      tick();
      n_checks++; if (val_a !== 64'd5 || val_b !== 64'd77) begin n_fail++; $display("FAIL b2b_e_bypass got %0d/%0d want 5/77", val_a, val_b); end
      wb(4'h6, 4'hF, 4'h7, 1'b0, 64'd6, 64'd0);
      dec(4'h5, 4'hF, 4'h7);
      tick();
      n_checks++; if (val_b !== 64'd6 || src_a !== 4'hF || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_opq_bypass got %0d/%h/%0b want 6/f/1", val_b, src_a, out_valid); end
      wb_valid = 1'b0;
      dec(4'h2, 4'h5, 4'hF);
      tick();
      idle();
      n_checks++; if (val_a !== 64'd262 || src_b !== 4'hF || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_third got %0d/%h/%0b want 262/f/1", val_a, src_b, out_valid); end
   endtask

   task automatic test_reset_midstream();
      dec(4'h6, 4'h2, 4'h2);
      tick();
      wb(4'h3, 4'hF, 4'h2, 1'b0, 64'd99, 64'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle();
      n_checks++; if (out_valid !== 1'b0 || src_a !== 4'hF || val_a !== 64'd0) begin n_fail++; $display("FAIL midreset_outs got %0b/%h/%0d want 0/f/0", out_valid, src_a, val_a); end
      for (int r = 0; r < 15; r += 2) begin
         dec(4'h6, 4'(r), 4'(r + 1));
         tick();
         n_checks++; if (val_a !== 64'd0 || val_b !== 64'd0) begin n_fail++; $display("FAIL midreset_reg%0d got %0d/%0d want 0/0", r, val_a, val_b); end
      end
      idle();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_write_read();
      test_cmov();
      test_bypass_m();
      test_popq();
      test_no_src();
      test_back_to_back();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
